// File: rtl/div_hilo_sched_if.sv
// Request/response bundle between EX and the iterative divide sequencer.
// The master side is the pipeline (EX), the slave side is div_hilo_sched.
interface div_hilo_sched_if;
    logic        start;
    logic        signed_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        dbz;

    modport master (
        output start, signed_op, opa, opb, flush,
        input  stall, busy, done, result, dbz
    );

    modport slave (
        input  start, signed_op, opa, opb, flush,
        output stall, busy, done, result, dbz
    );
endinterface

// File: rtl/div_hilo_sched.sv
// Iterative restoring DIV/DIVU sequencer feeding HI/LO with {remainder,quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |opa| < |opb|.
module div_hilo_sched #(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    div_hilo_sched_if.slave  dif
);
    localparam int N = 32 / ITERS_PER_CYCLE;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;
    logic        dbz_q, dbz_d;

    logic [31:0] opa_mag, opb_mag;
    logic        early_out;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fix, rem_fix;

    assign opa_mag = (dif.signed_op && dif.opa[31]) ? (32'd0 - dif.opa) : dif.opa;
    assign opb_mag = (dif.signed_op && dif.opb[31]) ? (32'd0 - dif.opb) : dif.opb;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (opa_mag < opb_mag);
`else
    assign early_out = 1'b0;
`endif

    // Shift-subtract steps for one clock; the quotient register doubles as the dividend shifter.
    always_comb begin
        // NOTE: blocking assignments here chain the steps combinationally within one cycle.
        rem_step = rem_q;
        quo_step = quo_q;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            rem_step = {rem_step[31:0], quo_step[31]};
            quo_step = {quo_step[30:0], 1'b0};
            if (rem_step >= {1'b0, dvs_q}) begin
                rem_step    = rem_step - {1'b0, dvs_q};
                quo_step[0] = 1'b1;
            end
        end
    end

    assign quo_fix = qneg_q ? (32'd0 - quo_step)       : quo_step;
    assign rem_fix = rneg_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        if (dif.flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dif.start) begin
                        if (dif.opb == 32'd0) begin
                            state_d = S_ZERO;
                            quo_d   = dif.opa;
                        end else if (early_out) begin
                            state_d  = S_DONE;
                            result_d = {dif.opa, 32'd0};
                            dbz_d    = 1'b0;
                        end else begin
                            state_d = S_RUN;
                            count_d = 5'd0;
                            rem_d   = 33'd0;
                            quo_d   = opa_mag;
                            dvs_d   = opb_mag;
                            qneg_d  = dif.signed_op & (dif.opa[31] ^ dif.opb[31]);
                            rneg_d  = dif.signed_op & dif.opa[31];
                        end
                    end
                end
                S_RUN: begin
                    rem_d   = rem_step;
                    quo_d   = quo_step;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'(N - 1)) begin
                        state_d  = S_DONE;
                        result_d = {rem_fix, quo_fix};
                        dbz_d    = 1'b0;
                    end
                end
                S_ZERO: begin
                    state_d  = S_DONE;
                    result_d = {quo_q, 32'hFFFF_FFFF};
                    dbz_d    = 1'b1;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    // The HI/LO strobe is suppressed if the instruction is annulled in its DONE cycle.
    assign dif.stall  = !dif.flush && ((state_q == S_IDLE && dif.start) ||
                                       state_q == S_RUN || state_q == S_ZERO);
    assign dif.busy   = (state_q != S_IDLE);
    assign dif.done   = (state_q == S_DONE) && !dif.flush;
    assign dif.dbz    = (state_q == S_DONE) && !dif.flush && dbz_q;
    assign dif.result = result_q;
endmodule

// File: tb/tb_div_hilo_sched.sv
// Self-checking bench for div_hilo_sched: directed corner cases plus random
// divides checked against an arithmetic reference model.
module tb_div_hilo_sched;
    localparam int ITERS = 1;
    localparam int N     = 32 / ITERS;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div_hilo_sched_if dif ();

    div_hilo_sched #(.ITERS_PER_CYCLE(ITERS)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit integer division (truncating, remainder takes dividend sign).
    function automatic logic [63:0] model_res(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic longint mag(input logic sg, input logic [31:0] v);
        longint s;
        if (sg) begin
            s = longint'($signed(v));
            return (s < 0) ? -s : s;
        end
        return {32'd0, v};
    endfunction

    function automatic int model_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (mag(sg, a) < mag(sg, b)) return 1;
`endif
        return N + 1;
    endfunction

    // Called at a negedge; starts one divide in cycle 0 and checks every cycle up to done.
    // Leaves start high at the following negedge (the IDLE cycle after DONE).
    task automatic run_op(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp_res;
        int          lat;
        exp_res = model_res(sg, a, b);
        lat     = model_lat(sg, a, b);
        dif.start     = 1'b1;
        dif.flush     = 1'b0;
        dif.signed_op = sg;
        dif.opa       = a;
        dif.opb       = b;
        for (int cyc = 0; cyc <= lat; cyc++) begin
            if (cyc > 0) begin
                dif.opa = $urandom;
                dif.opb = $urandom;
            end
            #1;
            total++;
            if (dif.stall !== (cyc < lat)) begin
                bad++;
                $display("FAIL %s stall cyc=%0d got=%b exp=%b", name, cyc, dif.stall, (cyc < lat));
            end
            total++;
            if (dif.busy !== (cyc >= 1)) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, dif.busy, (cyc >= 1));
            end
            total++;
            if (dif.done !== (cyc == lat)) begin
                bad++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, dif.done, (cyc == lat));
            end
            if (cyc == lat) begin
                total++;
                if (dif.result !== exp_res) begin
                    bad++;
                    $display("FAIL %s result got=%h exp=%h", name, dif.result, exp_res);
                end
                total++;
                if (dif.dbz !== (b == 32'd0)) begin
                    bad++;
                    $display("FAIL %s dbz got=%b exp=%b", name, dif.dbz, (b == 32'd0));
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        dif.start = 1'b0;
        dif.flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        dif.start = 1'b0;
        dif.flush = 1'b0;
        dif.signed_op = 1'b0;
        dif.opa   = 32'd0;
        dif.opb   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({dif.stall, dif.busy, dif.done, dif.dbz} !== 4'b0000) begin
            bad++;
            $display("FAIL reset flags got=%b exp=0000", {dif.stall, dif.busy, dif.done, dif.dbz});
        end
        total++;
        if (dif.result !== 64'd0) begin
            bad++;
            $display("FAIL reset result got=%h exp=0", dif.result);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        go_idle();
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        go_idle();
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        go_idle();
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        go_idle();
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        go_idle();
    endtask

    task automatic test_dbz();
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        go_idle();
        run_op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);
        go_idle();
    endtask

    task automatic test_early_out();
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10);
        go_idle();
        run_op("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10);
        go_idle();
    endtask

    // DIVU 100/7 flushed in cycle 10, then DIVU 9/3 started in cycle 12 (done in 45).
    task automatic test_flush();
        dif.signed_op = 1'b0;
        dif.opa       = 32'd100;
        dif.opb       = 32'd7;
        for (int cyc = 0; cyc <= 11; cyc++) begin
            dif.start = (cyc <= 10);
            dif.flush = (cyc == 10);
            #1;
            total++;
            if (dif.stall !== (cyc < 10)) begin
                bad++;
                $display("FAIL flush stall cyc=%0d got=%b exp=%b", cyc, dif.stall, (cyc < 10));
            end
            total++;
            if (dif.busy !== (cyc >= 1 && cyc <= 10)) begin
                bad++;
                $display("FAIL flush busy cyc=%0d got=%b exp=%b", cyc, dif.busy, (cyc >= 1 && cyc <= 10));
            end
            total++;
            if (dif.done !== 1'b0 || dif.dbz !== 1'b0) begin
                bad++;
                $display("FAIL flush done cyc=%0d got=%b%b exp=00", cyc, dif.done, dif.dbz);
            end
            @(posedge clk);
            @(negedge clk);
        end
        run_op("after_flush_9_3", 1'b0, 32'd9, 32'd3);
        go_idle();
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 1'b0, 32'd1000, 32'd33);
        run_op("b2b_second", 1'b1, 32'hFFFF_FC18, 32'd7);
        run_op("b2b_third", 1'b0, 32'd77, 32'd0);
        go_idle();
        #1;
        total++;
        if (dif.result !== {32'd77, 32'hFFFF_FFFF} || dif.done !== 1'b0 || dif.dbz !== 1'b0) begin
            bad++;
            $display("FAIL hold result got=%h done=%b dbz=%b exp=%h", dif.result, dif.done, dif.dbz,
                     {32'd77, 32'hFFFF_FFFF});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        sg;
        for (int k = 0; k < 24; k++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin b = $urandom; a = 32'($urandom_range(0, 255)); end
                default: b = $urandom;
            endcase
            if (sg && $urandom_range(0, 1) == 1) b = 32'd0 - b;
            run_op("random", sg, a, b);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
    endtask

    task automatic test_rst_mid();
        dif.start     = 1'b1;
        dif.flush     = 1'b0;
        dif.signed_op = 1'b0;
        dif.opa       = 32'd100;
        dif.opb       = 32'd7;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst       = 1'b1;
        dif.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            total++;
            if ({dif.stall, dif.busy, dif.done, dif.dbz} !== 4'b0000 || dif.result !== 64'd0) begin
                bad++;
                $display("FAIL rst_mid cyc=%0d flags=%b result=%h exp flags=0000 result=0",
                         cyc, {dif.stall, dif.busy, dif.done, dif.dbz}, dif.result);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_dbz();
        test_early_out();
        test_flush();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
